// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the iterative divider and its trial-subtract stage.
//   div_state_t : divider FSM states (IDLE, BUSY, DONE)
//   DIV_WIDTH   : default operand/result width
//   DIV_CNT_W   : width of the iteration counter for DIV_WIDTH
package alu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// div_sub_stage: combinational (WIDTH+1)-bit trial subtractor, o_diff = i_rem - i_dvs.
// It is the ALU adder datapath with the B operand inverted and carry-in 1.
// Ports:
//   i_rem    in  WIDTH+1  minuend (partial remainder)
//   i_dvs    in  WIDTH+1  subtrahend (divisor magnitude)
//   o_diff   out WIDTH+1  difference, modulo 2^(WIDTH+1)
//   o_borrow out 1        high when i_rem < i_dvs (adder carry-out low)
module div_sub_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] i_rem,
  input  logic [WIDTH:0] i_dvs,
  output logic [WIDTH:0] o_diff,
  output logic           o_borrow
);

  logic [WIDTH+1:0] w_sum;

  // A + ~B + 1, one bit wider so the adder's carry-out is visible.
  assign w_sum    = {1'b0, i_rem} + {1'b0, ~i_dvs} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign o_diff   = w_sum[WIDTH:0];
  assign o_borrow = ~w_sum[WIDTH+1];

endmodule

// File: rtl/div_iter_alu.sv
// div_iter_alu: iterative restoring divider, one quotient bit per cycle.
// Serves DIV/DIVU/REM/REMU next to the combinational ALU.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operation on is_signed).
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   dividend, divisor WIDTH-bit operands
//   is_signed         signed operation (only honoured with DIV_SIGNED_EN)
//   out_valid/out_ready result handshake; outputs hold until accepted
//   quotient, remainder WIDTH-bit results
//   div_by_zero       divisor was zero; qualified by out_valid
//   dbg_state         current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a valid source holds its data stable until that edge.
module div_iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       r_state;
  div_state_t       w_next_state;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_raw;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = w_div_zero ? DONE : BUSY;
      end
      BUSY: begin
        if (r_cnt == '0) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept   = in_valid & (r_state == IDLE);
  assign w_div_zero = (divisor == '0);
  assign dbg_state  = r_state;

  // ---------------------------------------------------------------------------
  // Sign pre/post-processing
  // ---------------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
  logic w_sgn_a;
  logic w_sgn_b;
  logic r_neg_q;
  logic r_neg_r;

  assign w_sgn_a = is_signed & dividend[WIDTH-1];
  assign w_sgn_b = is_signed & divisor[WIDTH-1];
  assign w_mag_a = w_sgn_a ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
  assign w_mag_b = w_sgn_b ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_sgn_a ^ w_sgn_b;
      r_neg_r <= w_sgn_a;
    end
  end

  // -2^(W-1) / -1: magnitude quotient is 2^(W-1) with equal signs, so it passes
  // through un-negated and already equals the required 0x80..0 result.
  assign w_q_final = r_neg_q ? (~w_q_raw    + {{(WIDTH-1){1'b0}}, 1'b1}) : w_q_raw;
  assign w_r_final = r_neg_r ? (~w_rem_next + {{(WIDTH-1){1'b0}}, 1'b1}) : w_rem_next;
`else
  logic w_unused_is_signed;

  assign w_unused_is_signed = is_signed;
  assign w_mag_a            = dividend;
  assign w_mag_b            = divisor;
  assign w_q_final          = w_q_raw;
  assign w_r_final          = w_rem_next;
`endif

  // ---------------------------------------------------------------------------
  // One restoring iteration
  // ---------------------------------------------------------------------------
  // The partial remainder before the shift is below 2^(k-1) on iteration k, so
  // dropping its top bit on the shift never loses information.
  assign w_rem_sh = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .i_rem    ({1'b0, w_rem_sh}),
    .i_dvs    ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_qbit     = ~w_borrow;
  assign w_rem_next = w_borrow ? w_rem_sh : w_diff[WIDTH-1:0];
  assign w_q_raw    = {r_dvd[WIDTH-2:0], w_qbit};

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_dvd <= w_mag_a;
      r_dvs <= w_mag_b;
      r_cnt <= CNT_W'(WIDTH - 1);
      if (w_div_zero) begin
        // Result is fixed; remainder is the raw dividend with no sign handling.
        r_quot <= '1;
        r_remo <= dividend;
        r_dbz  <= 1'b1;
      end else begin
        r_dbz <= 1'b0;
      end
    end else if (r_state == BUSY) begin
      r_rem <= w_rem_next;
      r_dvd <= w_q_raw;
      if (r_cnt == '0) begin
        r_quot <= w_q_final;
        r_remo <= w_r_final;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_iter_alu.sv
// Self-checking bench for div_iter_alu (WIDTH=32). The expected results come
// from plain SystemVerilog division on the operands, with the divide-by-zero
// and signed-overflow rules applied explicitly. Honours DIV_SIGNED_EN.
module tb_div_iter_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  div_iter_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: arithmetic straight from the division rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dz = (b == 0);
    if (b == 0) begin
      q = {W{1'b1}};
      r = a;
    end else begin
      q = a / b;
      r = a % b;
`ifdef DIV_SIGNED_EN
      if (s) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
      end
`else
      if (s) q = a / b;  // signed request is served as unsigned
`endif
    end
  endtask

  // Full operation: accept, latency check, result check, optional backpressure
  // for 'hold' cycles with a stray in_valid, then release.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input int hold);
    logic [W-1:0] eq, er;
    logic         edz;
    int           cyc;
    model(a, b, s, eq, er, edz);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, W'(in_ready), W'(1));
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk);  // accept edge
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".out_valid"}, W'(out_valid), W'(1));
    check({tag, ".latency"}, W'(cyc), (b == 0) ? W'(1) : W'(W + 1));
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".div_by_zero"}, W'(div_by_zero), W'(edz));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = $urandom_range(1, 50);
      @(posedge clk);
      #1;
      check({tag, ".bp_in_ready"}, W'(in_ready), W'(0));
      check({tag, ".bp_out_valid"}, W'(out_valid), W'(1));
      check({tag, ".bp_quotient"}, quotient, eq);
      check({tag, ".bp_remainder"}, remainder, er);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".released_out_valid"}, W'(out_valid), W'(0));
    check({tag, ".released_in_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", W'(in_ready), W'(1));
    check("reset.out_valid", W'(out_valid), W'(0));
    check("reset.quotient", quotient, W'(0));
    check("reset.remainder", remainder, W'(0));
    check("reset.div_by_zero", W'(div_by_zero), W'(0));
    check("reset.state", W'(dbg_state), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    do_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
    do_op("u1234_0", 32'h1234, 32'd0, 1'b0, 0);
    do_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    do_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("s_zero", 32'hFFFF_FFF0, 32'd0, 1'b1, 1);
    do_op("u_max_max", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0);
    do_op("backpressure", 32'd1000, 32'd10, 1'b0, 10);

    // reset in the middle of an operation
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd3;
    is_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid", W'(out_valid), W'(0));
    check("midreset.in_ready", W'(in_ready), W'(1));
    check("midreset.quotient", quotient, W'(0));
    check("midreset.remainder", remainder, W'(0));
    check("midreset.div_by_zero", W'(div_by_zero), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_reset_9_3", 32'd9, 32'd3, 1'b0, 0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = $urandom_range(1, 32'hFFFF);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1 && rb != 0 && $urandom_range(0, 1) == 1) rb = -rb;
      rs = $urandom_range(0, 1);
      do_op("random", ra, rb, rs, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
